// File: rtl/processor_pkg.sv
// Shared constants for the processor: widths, PC index, bus mux codes and ALU/opcode numbers.
// Used by both the datapath and the control unit.
package processor_pkg;
    localparam int DW   = 10;
    localparam int NREG = 8;

    localparam logic [2:0] PC_IDX = 3'd7;

    localparam logic [2:0] MUX_DIN = 3'b001;
    localparam logic [2:0] MUX_RB  = 3'b010;
    localparam logic [2:0] MUX_ALU = 3'b100;

    // 0..7 are ALU operations; 8..10 are memory/immediate opcodes that only the control unit decodes
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_MVNZ = 4'd6;
    localparam logic [3:0] OP_MV   = 4'd7;
    localparam logic [3:0] OP_LD   = 4'd8;
    localparam logic [3:0] OP_ST   = 4'd9;
    localparam logic [3:0] OP_MVI  = 4'd10;
endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: operands A (a) and register-bank read (b); g is the current G for MVNZ.
module alu
    import processor_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] g,
    input  logic [2:0]    op,
    output logic [DW-1:0] result
);
    logic big_shift;

    // shifting a 10-bit value by 10 or more clears it
    assign big_shift = (b >= DW[DW-1:0]);

    always_comb begin
        result = '0;
        case ({1'b0, op})
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_SLL:  result = big_shift ? '0 : (a << b[3:0]);
            OP_SRL:  result = big_shift ? '0 : (a >> b[3:0]);
            OP_SLT:  result = {{(DW-1){1'b0}}, (a < b)};
            OP_MVNZ: result = (g != '0) ? b : a;
            OP_MV:   result = b;
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/datapath.sv
// Processor datapath: register bank R0..R7 (R7 = PC), IR, A, G, ADDR, DOUT, W and the bus mux.
module datapath
    import processor_pkg::*;
(
    input  logic          Clock,
    input  logic          reset,
    input  logic [DW-1:0] DIN,
    input  logic          incr_pc,
    input  logic          WrRegisterBank,
    input  logic          WrIR,
    input  logic          WrA,
    input  logic          WrG,
    input  logic          WrW,
    input  logic          WrDataOut,
    input  logic          WrAddressOut,
    input  logic [2:0]    multControl,
    input  logic [2:0]    addrRegisterBank,
    input  logic [2:0]    aluControl,
    output logic [DW-1:0] IR,
    output logic [DW-1:0] ADDR,
    output logic [DW-1:0] DOUT,
    output logic          W,
    output logic [DW-1:0] Bus
);
    logic [NREG-1:0][DW-1:0] r;
    logic [DW-1:0] rb, a_q, g_q, alu_res;

    assign rb = r[addrRegisterBank];

    always_comb begin
        Bus = '0;
        case (multControl)
            MUX_DIN: Bus = DIN;
            MUX_RB:  Bus = rb;
            MUX_ALU: Bus = g_q;
            default: Bus = '0;
        endcase
    end

    alu u_alu (
        .a      (a_q),
        .b      (rb),
        .g      (g_q),
        .op     (aluControl),
        .result (alu_res)
    );

    // bank write is after the PC increment so a write to R7 overrides it
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            r <= '0;
        end else begin
            if (incr_pc)        r[PC_IDX]           <= r[PC_IDX] + 1'b1;
            if (WrRegisterBank) r[addrRegisterBank] <= Bus;
        end
    end

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            IR   <= '0;
            a_q  <= '0;
            g_q  <= '0;
            ADDR <= '0;
            DOUT <= '0;
            W    <= 1'b0;
        end else begin
            if (WrIR)         IR   <= DIN;
            if (WrA)          a_q  <= Bus;
            if (WrG)          g_q  <= alu_res;
            if (WrAddressOut) ADDR <= Bus;
            if (WrDataOut)    DOUT <= Bus;
            W <= WrW;
        end
    end
endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Clock  input  1  rising-edge clock for every register in the block.
REQ-002 reset  input  1  asynchronous, active-high; clears all state.
REQ-003 DIN  input  10  read data from instruction/data memory.
REQ-004 incr_pc  input  1  increment R7 (PC) at the next edge.
REQ-005 WrRegisterBank  input  1  write Bus into R[addrRegisterBank].
REQ-006 WrIR, WrA, WrG, WrW, WrDataOut, WrAddressOut  input  1 each  load enables for IR, A, G, W, DOUT and ADDR.
REQ-007 multControl  input  3  Bus source select, one-hot: 3'b001 = DIN, 3'b010 = register bank, 3'b100 = ALU result (G).
REQ-008 addrRegisterBank  input  3  register-bank read/write index.
REQ-009 aluControl  input  3  ALU operation: 0 ADD, 1 SUB, 2 AND, 3 SLL, 4 SRL, 5 SLT, 6 MVNZ, 7 MV.
REQ-010 IR  output  10  instruction register; feeds the control unit's data input.
REQ-011 ADDR  output  10  memory address register.
REQ-012 DOUT  output  10  memory write-data register.
REQ-013 W  output  1  registered memory write enable.
REQ-014 Bus  output  10  current internal bus value, for observation only.

Function
REQ-015 The register bank SHALL hold eight 10-bit registers R0..R7; R7 is the PC.
REQ-016 Register-bank read SHALL be combinational: RB = R[addrRegisterBank].
REQ-017 Bus SHALL be combinational from the mux selection:
  - DIN when multControl = 3'b001.
  - RB when multControl = 3'b010.
  - G when multControl = 3'b100.
  - 10'd0 for any other multControl value.
REQ-018 On each rising edge, each enabled register SHALL load: R[addrRegisterBank] <= Bus, IR <= DIN, A <= Bus, DOUT <= Bus, ADDR <= Bus, W <= WrW.
REQ-019 W SHALL be a one-cycle registered copy of WrW, not a sticky flag.
REQ-020 The ALU SHALL be combinational on operands A and RB, with a 10-bit result; G <= result when WrG is high.
  - ADD: A + RB, modulo 1024.
  - SUB: A - RB, modulo 1024.
  - AND: A & RB.
  - SLL: A << RB, logical, zero-fill.
  - SRL: A >> RB, logical, zero-fill.
  - SLT: 1 if A < RB unsigned, else 0.
  - MVNZ: RB if current G != 0, else A.
  - MV: RB.
REQ-021 A shift amount of 10 or more SHALL yield 10'd0.
REQ-022 incr_pc SHALL make R7 <= R7 + 1, wrapping from 1023 to 0.
REQ-023 If incr_pc and WrRegisterBank with addrRegisterBank = 7 occur in the same cycle, the bank write SHALL win and the increment SHALL be discarded.
REQ-024 Every register SHALL sample values present before the edge; e.g. ADDR <= R7 together with incr_pc captures the pre-increment PC.
REQ-025 All load enables SHALL be independent; any combination may be asserted in one cycle.
REQ-026 Latency SHALL be one edge from enable to updated output; Bus and the ALU SHALL have zero latency.

Reset
REQ-027 reset high SHALL immediately force R0..R7, IR, A, G, ADDR and DOUT to 10'd0 and W to 0, regardless of Clock.
REQ-028 Reset asserted mid-instruction SHALL discard all pending loads; the first edge after release SHALL behave as a normal edge using the current enables.
REQ-029 After reset, ADDR SHALL be 0, so the first fetch reads memory word 0.

Structure
REQ-030 A shared package processor_pkg SHALL hold:
  - data width (10) and register count (8);
  - PC index (7);
  - multControl one-hot codes (DIN, RB, ALU);
  - ALU/opcode constants 0..10.
REQ-031 The control unit and this block SHALL both use processor_pkg.
REQ-032 The ALU SHALL be a separate combinational sub-module named alu (inputs a, b, g, op; output result).
REQ-033 The register bank, IR, A, G, ADDR, DOUT, W and the bus mux SHALL reside in datapath.

Verification
REQ-034 Reset, then pulse incr_pc for 3 cycles -> R7 = 3 and all other registers = 0; reset mid-run -> R7 = 0 at once, asynchronously.
REQ-035 DIN = 10'h005 with multControl = DIN and WrRegisterBank, addr = 2 -> R2 = 5; then addr = 2, multControl = RB, WrA -> A = 5.
REQ-036 ALU cases with A = 5 and R3 = 3:
  - ADD -> G = 8; SUB -> G = 2; AND -> G = 1;
  - SLL -> G = 40; SRL -> G = 0; SLT -> G = 0;
  - SLL with R3 = 12 -> G = 0;
  - SUB with A = 0, R3 = 1 -> G = 1023.
REQ-037 MVNZ with G = 0, A = 7, RB = 9 -> G = 7; MVNZ with G = 4 -> G = 9.
REQ-038 R7 = 1023 with incr_pc -> R7 = 0; R7 = 10, incr_pc plus WrRegisterBank to 7 with Bus = 100 -> R7 = 100; ADDR <= R7 together with incr_pc at R7 = 4 -> ADDR = 4, R7 = 5.
REQ-039 Store sequence: R1 = 9, R2 = 20; WrDataOut from R1, then WrAddressOut from R2 with WrW -> DOUT = 9, ADDR = 20, W high for exactly one cycle; multControl = 3'b011 -> Bus = 0.
